// File: rtl/uart_byte_rx_led.sv
// 8N1 UART byte receiver, LSB first, with a one-cycle done strobe, a frame-error strobe
// and an LED that toggles on every good byte.
module uart_byte_rx_led #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       i_sysclk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_led
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam int unsigned CW       = $clog2(BAUD_DIV + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_sync1, r_rx_s, r_rx_d;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_done, r_ferr, r_led;
  logic            w_fall, w_half_tick, w_bit_tick;
  logic            w_shift_en, w_done, w_ferr;

  assign w_fall      = r_rx_d & ~r_rx_s;
  assign w_half_tick = (r_cnt == CW'(HALF_DIV - 1));
  assign w_bit_tick  = (r_cnt == CW'(BAUD_DIV - 1));

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_done       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      StIdle:  if (w_fall) w_state_next = StStart;
      StStart: if (w_half_tick) w_state_next = r_rx_s ? StIdle : StData;
      StData: begin
        if (w_bit_tick) begin
          w_shift_en = 1'b1;
          if (r_idx == 3'd7) w_state_next = StStop;
        end
      end
      StStop: begin
        // Leaving at the stop-bit centre lets a back-to-back start edge be caught.
        if (w_bit_tick) begin
          if (r_rx_s) begin
            w_done       = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_ferr       = 1'b1;
            w_state_next = StBreak;
          end
        end
      end
      StBreak: if (r_rx_s) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sync1 <= i_uart_rx;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
      r_done  <= w_done;
      r_ferr  <= w_ferr;

      if (r_state == StIdle || w_state_next != r_state || w_bit_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == StStart) begin
        r_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_idx          <= r_idx + 3'd1;
        r_shift[r_idx] <= r_rx_s;
      end

      if (w_done) begin
        r_data <= r_shift;
        r_led  <= ~r_led;
      end
    end
  end

  assign o_data      = r_data;
  assign o_rx_done   = r_done;
  assign o_frame_err = r_ferr;
  assign o_led       = r_led;

endmodule

// File: tb/tb_uart_byte_rx_led.sv
// Directed plus randomized frame stimulus for uart_byte_rx_led, checked against a
// byte-level model of what a receiver should report.
module tb_uart_byte_rx_led;

  localparam int unsigned ClkFreq = 50_000_000;
  localparam int unsigned Baud    = 115200;
  localparam int unsigned Bit     = ClkFreq / Baud;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       done, ferr, led;

  always #10 clk = ~clk;

  uart_byte_rx_led #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) u_dut (
    .i_sysclk   (clk),
    .i_rst      (rst),
    .i_uart_rx  (rx),
    .o_data     (data),
    .o_rx_done  (done),
    .o_frame_err(ferr),
    .o_led      (led)
  );

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         exp_ferr = 0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_led  = 1'b0;
  int         n_checks = 0;
  int         n_pass   = 0;

  always @(negedge clk) begin
    if (done) got_q.push_back(data);
    if (ferr) ferr_cnt++;
    if (done && ferr) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic drive_bits(input logic level, input int nbits);
    rx = level;
    repeat (nbits * Bit) @(negedge clk);
  endtask

  // Model: a good stop bit delivers the byte and toggles the LED; a bad one only flags.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(b[i], 1);
    drive_bits(stop_ok, 1);
    if (stop_ok) begin
      exp_q.push_back(b);
      exp_data = b;
      exp_led  = ~exp_led;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic step_check(input string tag);
    chk({tag, "_ndone"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_byte"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
    end
    got_q.delete();
    exp_q.delete();
    chk({tag, "_data"}, {24'h0, data}, {24'h0, exp_data});
    chk({tag, "_led"}, {31'h0, led}, {31'h0, exp_led});
    chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk({tag, "_both"}, both_cnt, 0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       ok;

    repeat (10) @(negedge clk);
    rst = 1'b0;
    chk("reset_data", {24'h0, data}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_ferr", {31'h0, ferr}, 32'h0);
    chk("reset_led", {31'h0, led}, 32'h0);
    repeat (20) @(negedge clk);

    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    step_check("t1_55");

    send_frame(8'hAA, 1'b1);
    send_frame(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    step_check("t2_b2b");

    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (Bit) @(negedge clk);
    step_check("t3_glitch");
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    step_check("t3_3c");

    send_frame(8'h3C, 1'b0);
    drive_bits(1'b0, 3);
    drive_bits(1'b1, 1);
    step_check("t4_break");
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    step_check("t4_81");

    // 0xF0: bits 0..3 low, reset in the middle of bit 4 (high).
    drive_bits(1'b0, 5);
    rx = 1'b1;
    repeat (Bit / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = 8'h00;
    exp_led  = 1'b0;
    chk("t5_rst_data", {24'h0, data}, 32'h0);
    chk("t5_rst_led", {31'h0, led}, 32'h0);
    chk("t5_rst_done", {31'h0, done}, 32'h0);
    repeat (Bit - Bit / 2 - 1) @(negedge clk);
    drive_bits(1'b1, 4);
    step_check("t5_aborted");
    send_frame(8'h0F, 1'b1);
    repeat (20) @(negedge clk);
    step_check("t5_0f");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    step_check("t6_three");

    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send_frame(rb, ok);
      if (!ok) begin
        drive_bits(1'b0, $urandom_range(0, 2));
        drive_bits(1'b1, 1);
      end else begin
        drive_bits(1'b1, $urandom_range(0, 2));
      end
      repeat (5) @(negedge clk);
      step_check("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
